// File: rtl/param_ram_if.sv
// Request/response bus for param_ram: one outstanding access, completion pulse on resp.
interface param_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  wr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  ready;
    logic                  resp;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, wr, addr, wdata, be,
        input  ready, resp, rdata, err
    );

    modport slave (
        input  req, wr, addr, wdata, be,
        output ready, resp, rdata, err
    );
endinterface

// File: rtl/param_ram.sv
// Single-port word RAM with byte enables and a programmable wait-state FSM (IDLE/BUSY/DONE).
// Optional PARAM_RAM_BOUNDS_CHECK_EN flags out-of-range addresses instead of aliasing them.
module param_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    param_ram_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam logic [7:0] LAT = 8'(LATENCY);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [7:0]        cnt;
    logic              wr_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic              oob_q;
    logic              oob_in;
    logic [DATA_W-1:0] rdata_q;
    logic              access;
    logic [DATA_W-1:0] mem [DEPTH];

`ifdef PARAM_RAM_BOUNDS_CHECK_EN
    assign oob_in = |(bus.addr >> AW);
`else
    logic unused_addr;
    assign oob_in      = 1'b0;
    assign unused_addr = ^bus.addr;
`endif

    // The access fires on the edge that finds the wait counter exhausted.
    assign access = rst_n && (state == BUSY) && (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state <= BUSY;
                        cnt   <= LAT;
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= DONE;
                        if (!wr_q) begin
                            rdata_q <= oob_q ? '0 : mem[idx_q];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are frozen at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.req) begin
            wr_q    <= bus.wr;
            idx_q   <= bus.addr[AW-1:0];
            wdata_q <= bus.wdata;
            be_q    <= bus.be;
            oob_q   <= oob_in;
        end
    end

    always_ff @(posedge clk) begin
        if (access && wr_q && !oob_q) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef PARAM_RAM_BOUNDS_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= oob_q;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.ready = (state == IDLE);
    assign bus.resp  = (state == DONE);
    assign bus.rdata = rdata_q;

endmodule
